// File: rtl/nand_page_buf.sv
// Multi-bank NAND page buffer: ping-pong bank ring between a byte-enabled fill
// side and a fixed-latency drain side, one shared single-clock RAM.
module nand_page_buf #(
  parameter  int unsigned DATA_W     = 32,
  parameter  int unsigned PAGE_WORDS = 528,
  parameter  int unsigned NUM_BANKS  = 2,
  parameter  int unsigned OUT_REG    = 0,
  localparam int unsigned AW         = $clog2(PAGE_WORDS),
  localparam int unsigned LW         = $clog2(PAGE_WORDS + 1),
  localparam int unsigned BW         = $clog2(NUM_BANKS),
  localparam int unsigned BEW        = DATA_W / 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WE,
  input  logic [AW-1:0]     WADDR,
  input  logic [DATA_W-1:0] WD,
  input  logic [BEW-1:0]    WBE,
  input  logic              W_COMMIT,
  input  logic [LW-1:0]     W_LEN,
  output logic              W_AVAIL,
  output logic [BW-1:0]     W_BANK,
  input  logic              RE,
  input  logic [AW-1:0]     RADDR,
  output logic [DATA_W-1:0] RD,
  output logic              RD_VALID,
  output logic              R_AVAIL,
  output logic [BW-1:0]     R_BANK,
  output logic [LW-1:0]     R_LEN,
  input  logic              R_RELEASE
);

  localparam int unsigned CW    = $clog2(NUM_BANKS + 1);
  localparam int unsigned PAW   = BW + AW;
  localparam int unsigned DEPTH = 1 << PAW;
  localparam logic [AW:0]   PAGE_LIM = PAGE_WORDS[AW:0];
  localparam logic [LW-1:0] LEN_MAX  = PAGE_WORDS[LW-1:0];
  localparam logic [CW-1:0] NB_CNT   = NUM_BANKS[CW-1:0];

  logic [BW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [LW-1:0]     len_q [NUM_BANKS];
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              w_avail, r_avail;
  logic              wr_ok, commit_ok, release_ok, re_ok, raddr_oob;
  logic [LW-1:0]     len_clamped;

  logic [PAW-1:0]    ra_q;
  logic              ra_oob_q, rv_q;
  logic [DATA_W-1:0] d1_q;
  logic              v1_q;

  assign w_avail     = count_q < NB_CNT;
  assign r_avail     = count_q != '0;
  assign wr_ok       = WE & w_avail & ({1'b0, WADDR} < PAGE_LIM);
  assign commit_ok   = W_COMMIT & w_avail;
  assign release_ok  = R_RELEASE & r_avail;
  assign re_ok       = RE & r_avail;
  assign raddr_oob   = {1'b0, RADDR} >= PAGE_LIM;
  assign len_clamped = (W_LEN > LEN_MAX) ? LEN_MAX : W_LEN;

  assign W_AVAIL = w_avail;
  assign R_AVAIL = r_avail;
  assign W_BANK  = wr_ptr_q;
  assign R_BANK  = rd_ptr_q;
  assign R_LEN   = len_q[rd_ptr_q];

  // Bank ring: simultaneous commit and release advance both pointers, count holds
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (commit_ok)  wr_ptr_d = wr_ptr_q + BW'(1);
    if (release_ok) rd_ptr_d = rd_ptr_q + BW'(1);
    case ({commit_ok, release_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < NUM_BANKS; i++) len_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (commit_ok) len_q[wr_ptr_q] <= len_clamped;
    end
  end

  // Fill-side RAM write; contents intentionally survive reset
  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      for (int unsigned b = 0; b < BEW; b++) begin
        if (WBE[b]) mem_q[{wr_ptr_q, WADDR}][8*b +: 8] <= WD[8*b +: 8];
      end
    end
  end

  // Read pipeline: address capture, then RAM data register
  always_ff @(posedge CLK) begin
    if (RST) begin
      rv_q     <= 1'b0;
      ra_q     <= '0;
      ra_oob_q <= 1'b0;
      v1_q     <= 1'b0;
      d1_q     <= '0;
    end else begin
      rv_q <= re_ok;
      if (re_ok) begin
        ra_q     <= {rd_ptr_q, RADDR};
        ra_oob_q <= raddr_oob;
      end
      v1_q <= rv_q;
      if (rv_q) d1_q <= ra_oob_q ? '0 : mem_q[ra_q];
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_W-1:0] d2_q;
    logic              v2_q;
    always_ff @(posedge CLK) begin
      if (RST) begin
        d2_q <= '0;
        v2_q <= 1'b0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) d2_q <= d1_q;
      end
    end
    assign RD       = d2_q;
    assign RD_VALID = v2_q;
  end else begin : g_noreg
    assign RD       = d1_q;
    assign RD_VALID = v1_q;
  end

endmodule

// File: tb/tb_nand_page_buf.sv
// Self-checking bench for nand_page_buf: directed scenarios plus randomized
// traffic against a bank-ring reference model.
module tb_nand_page_buf;

  localparam int DW   = 32;
  localparam int PW   = 528;
  localparam int NB   = 2;
  localparam int OREG = 0;
  localparam int LAT  = (OREG != 0) ? 2 : 1;
  localparam int AW   = 10;
  localparam int LW   = 10;
  localparam int BW   = 1;

  logic          CLK = 1'b0;
  logic          RST;
  logic          WE;
  logic [AW-1:0] WADDR;
  logic [DW-1:0] WD;
  logic [3:0]    WBE;
  logic          W_COMMIT;
  logic [LW-1:0] W_LEN;
  logic          W_AVAIL;
  logic [BW-1:0] W_BANK;
  logic          RE;
  logic [AW-1:0] RADDR;
  logic [DW-1:0] RD;
  logic          RD_VALID;
  logic          R_AVAIL;
  logic [BW-1:0] R_BANK;
  logic [LW-1:0] R_LEN;
  logic          R_RELEASE;

  int checks   = 0;
  int failures = 0;

  // Reference model: flat page store, length table, ring pointers, read pipe
  logic [DW-1:0] m_mem [NB*PW];
  int            m_len [NB];
  int            m_wp, m_rp, m_cnt;
  logic          pv [LAT+1];
  logic [DW-1:0] pd [LAT+1];
  logic          e_rv;
  logic [DW-1:0] e_rd;

  always #5 CLK = ~CLK;

  nand_page_buf #(
    .DATA_W(DW), .PAGE_WORDS(PW), .NUM_BANKS(NB), .OUT_REG(OREG)
  ) dut (
    .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR), .WD(WD), .WBE(WBE),
    .W_COMMIT(W_COMMIT), .W_LEN(W_LEN), .W_AVAIL(W_AVAIL), .W_BANK(W_BANK),
    .RE(RE), .RADDR(RADDR), .RD(RD), .RD_VALID(RD_VALID), .R_AVAIL(R_AVAIL),
    .R_BANK(R_BANK), .R_LEN(R_LEN), .R_RELEASE(R_RELEASE)
  );

  task automatic set_idle();
    WE = 1'b0; W_COMMIT = 1'b0; RE = 1'b0; R_RELEASE = 1'b0;
    WBE = 4'hF; W_LEN = '0; WADDR = '0; RADDR = '0; WD = '0;
  endtask

  // One clock edge: advance the model with the inputs the DUT samples
  task automatic tick();
    bit wav, rav;
    int idx;
    @(posedge CLK);
    if (RST) begin
      m_wp = 0; m_rp = 0; m_cnt = 0;
      for (int k = 0; k < NB; k++) m_len[k] = 0;
      for (int k = 0; k <= LAT; k++) begin pv[k] = 1'b0; pd[k] = '0; end
      e_rv = 1'b0; e_rd = '0;
    end else begin
      wav = (m_cnt < NB);
      rav = (m_cnt > 0);
      for (int k = LAT; k > 0; k--) begin pv[k] = pv[k-1]; pd[k] = pd[k-1]; end
      pv[0] = RE && rav;
      pd[0] = (int'(RADDR) >= PW) ? '0 : m_mem[m_rp*PW + int'(RADDR)];
      e_rv = pv[LAT];
      if (e_rv) e_rd = pd[LAT];
      if (WE && wav && int'(WADDR) < PW) begin
        idx = m_wp*PW + int'(WADDR);
        for (int b = 0; b < 4; b++) if (WBE[b]) m_mem[idx][8*b +: 8] = WD[8*b +: 8];
      end
      if (W_COMMIT && wav) begin
        m_len[m_wp] = (int'(W_LEN) > PW) ? PW : int'(W_LEN);
        m_wp = (m_wp + 1) % NB;
        m_cnt++;
      end
      if (R_RELEASE && rav) begin
        m_rp = (m_rp + 1) % NB;
        m_cnt--;
      end
    end
    #1;
  endtask

  task automatic write_word(input int a, input logic [DW-1:0] d, input logic [3:0] be);
    WE = 1'b1; WADDR = AW'(a); WD = d; WBE = be;
    tick();
    WE = 1'b0; WBE = 4'hF;
  endtask

  task automatic commit(input int len);
    W_COMMIT = 1'b1; W_LEN = LW'(len);
    tick();
    W_COMMIT = 1'b0;
  endtask

  task automatic release_bank();
    R_RELEASE = 1'b1;
    tick();
    R_RELEASE = 1'b0;
  endtask

  // Issue one read and wait until its result is on RD
  task automatic read_word(input int a);
    RE = 1'b1; RADDR = AW'(a);
    tick();
    RE = 1'b0;
    repeat (LAT) tick();
  endtask

  task automatic test_reset();
    RST = 1'b1; set_idle();
    tick(); tick();
    RST = 1'b0;
    checks += 6;
    if (RD_VALID !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", RD_VALID); end
    if (RD !== '0)         begin failures++; $display("FAIL reset_rd got=%h exp=0", RD); end
    if (W_AVAIL !== 1'b1)  begin failures++; $display("FAIL reset_w_avail got=%b exp=1", W_AVAIL); end
    if (R_AVAIL !== 1'b0)  begin failures++; $display("FAIL reset_r_avail got=%b exp=0", R_AVAIL); end
    if (W_BANK !== '0)     begin failures++; $display("FAIL reset_w_bank got=%0d exp=0", W_BANK); end
    if (R_BANK !== '0)     begin failures++; $display("FAIL reset_r_bank got=%0d exp=0", R_BANK); end
  endtask

  task automatic test_fill_drain();
    logic [DW-1:0] exp;
    for (int i = 0; i < PW; i++) write_word(i, 32'hA500_0000 + DW'(i), 4'hF);
    commit(528);
    checks += 4;
    if (R_AVAIL !== 1'b1) begin failures++; $display("FAIL fill_r_avail got=%b exp=1", R_AVAIL); end
    if (R_BANK !== '0)    begin failures++; $display("FAIL fill_r_bank got=%0d exp=0", R_BANK); end
    if (R_LEN !== 10'd528) begin failures++; $display("FAIL fill_r_len got=%0d exp=528", R_LEN); end
    if (W_BANK !== 1'b1)  begin failures++; $display("FAIL fill_w_bank got=%0d exp=1", W_BANK); end
    for (int i = 0; i < PW + LAT; i++) begin
      RE = (i < PW); RADDR = AW'(i);
      tick();
      checks++;
      if (RD_VALID !== (i >= LAT)) begin
        failures++; $display("FAIL drain_valid i=%0d got=%b exp=%b", i, RD_VALID, (i >= LAT));
      end
      if (i >= LAT) begin
        exp = 32'hA500_0000 + DW'(i - LAT);
        checks++;
        if (RD !== exp) begin failures++; $display("FAIL drain_data i=%0d got=%h exp=%h", i - LAT, RD, exp); end
      end
    end
    RE = 1'b0;
    release_bank();
    checks += 2;
    if (R_AVAIL !== 1'b0) begin failures++; $display("FAIL drain_release_r_avail got=%b exp=0", R_AVAIL); end
    if (R_BANK !== 1'b1)  begin failures++; $display("FAIL drain_release_r_bank got=%0d exp=1", R_BANK); end
  endtask

  task automatic test_byte_enable();
    write_word(5, 32'h1122_3344, 4'hF);
    write_word(5, 32'hAABB_CCDD, 4'b0101);
    commit(6);
    read_word(5);
    checks += 3;
    if (RD_VALID !== 1'b1)     begin failures++; $display("FAIL be_valid got=%b exp=1", RD_VALID); end
    if (RD !== 32'h11BB_33DD)  begin failures++; $display("FAIL be_data got=%h exp=11bb33dd", RD); end
    if (R_LEN !== 10'd6)       begin failures++; $display("FAIL be_r_len got=%0d exp=6", R_LEN); end
    tick();
    checks++;
    if (RD_VALID !== 1'b0) begin failures++; $display("FAIL be_valid_pulse got=%b exp=0", RD_VALID); end
    release_bank();
  endtask

  task automatic test_ping_pong();
    write_word(0, 32'hB0B0_0000, 4'hF);
    commit(1);
    write_word(0, 32'hB1B1_0001, 4'hF);
    commit(2);
    checks += 3;
    if (W_AVAIL !== 1'b0) begin failures++; $display("FAIL pp_full_w_avail got=%b exp=0", W_AVAIL); end
    if (R_AVAIL !== 1'b1) begin failures++; $display("FAIL pp_full_r_avail got=%b exp=1", R_AVAIL); end
    if (W_BANK !== '0)    begin failures++; $display("FAIL pp_full_w_bank got=%0d exp=0", W_BANK); end
    WE = 1'b1; WADDR = '0; WD = 32'hDEAD_BEEF; W_COMMIT = 1'b1; W_LEN = 10'd9;
    tick();
    WE = 1'b0; W_COMMIT = 1'b0;
    checks += 3;
    if (W_AVAIL !== 1'b0) begin failures++; $display("FAIL pp_drop_w_avail got=%b exp=0", W_AVAIL); end
    if (W_BANK !== '0)    begin failures++; $display("FAIL pp_drop_w_bank got=%0d exp=0", W_BANK); end
    if (R_LEN !== 10'd1)  begin failures++; $display("FAIL pp_drop_r_len got=%0d exp=1", R_LEN); end
    read_word(0);
    checks++;
    if (RD !== 32'hB0B0_0000) begin failures++; $display("FAIL pp_bank0_data got=%h exp=b0b00000", RD); end
    release_bank();
    checks += 4;
    if (W_AVAIL !== 1'b1) begin failures++; $display("FAIL pp_rel_w_avail got=%b exp=1", W_AVAIL); end
    if (W_BANK !== '0)    begin failures++; $display("FAIL pp_rel_w_bank got=%0d exp=0", W_BANK); end
    if (R_BANK !== 1'b1)  begin failures++; $display("FAIL pp_rel_r_bank got=%0d exp=1", R_BANK); end
    if (R_LEN !== 10'd2)  begin failures++; $display("FAIL pp_rel_r_len got=%0d exp=2", R_LEN); end
    read_word(0);
    checks++;
    if (RD !== 32'hB1B1_0001) begin failures++; $display("FAIL pp_bank1_data got=%h exp=b1b10001", RD); end
    release_bank();
  endtask

  task automatic test_commit_release();
    write_word(0, 32'hC0C0_C0C0, 4'hF);
    commit(600);
    checks++;
    if (R_LEN !== 10'd528) begin failures++; $display("FAIL cr_clamp got=%0d exp=528", R_LEN); end
    write_word(0, 32'hC1C1_C1C1, 4'hF);
    W_COMMIT = 1'b1; W_LEN = 10'd7; R_RELEASE = 1'b1; RE = 1'b1; RADDR = '0;
    tick();
    W_COMMIT = 1'b0; R_RELEASE = 1'b0; RE = 1'b0;
    checks += 5;
    if (R_AVAIL !== 1'b1) begin failures++; $display("FAIL cr_r_avail got=%b exp=1", R_AVAIL); end
    if (W_AVAIL !== 1'b1) begin failures++; $display("FAIL cr_w_avail got=%b exp=1", W_AVAIL); end
    if (W_BANK !== '0)    begin failures++; $display("FAIL cr_w_bank got=%0d exp=0", W_BANK); end
    if (R_BANK !== 1'b1)  begin failures++; $display("FAIL cr_r_bank got=%0d exp=1", R_BANK); end
    if (R_LEN !== 10'd7)  begin failures++; $display("FAIL cr_r_len got=%0d exp=7", R_LEN); end
    repeat (LAT) tick();
    checks++;
    if (RD_VALID !== 1'b1 || RD !== 32'hC0C0_C0C0) begin
      failures++; $display("FAIL cr_old_bank_read got=%b/%h exp=1/c0c0c0c0", RD_VALID, RD);
    end
    release_bank();
  endtask

  task automatic test_oob_empty();
    RE = 1'b1; RADDR = 10'd3;
    for (int i = 0; i <= LAT; i++) begin
      tick();
      RE = 1'b0;
      checks++;
      if (RD_VALID !== 1'b0) begin failures++; $display("FAIL empty_read_valid i=%0d got=%b exp=0", i, RD_VALID); end
    end
    write_word(530, 32'h0BAD_0BAD, 4'hF);
    write_word(3, 32'h3333_3333, 4'hF);
    commit(4);
    read_word(528);
    checks++;
    if (RD_VALID !== 1'b1 || RD !== '0) begin
      failures++; $display("FAIL oob_read got=%b/%h exp=1/00000000", RD_VALID, RD);
    end
    read_word(3);
    checks++;
    if (RD !== 32'h3333_3333) begin failures++; $display("FAIL oob_after_data got=%h exp=33333333", RD); end
    release_bank();
  endtask

  task automatic test_rst_inflight();
    write_word(9, 32'h5A5A_5A5A, 4'hF);
    commit(10);
    read_word(9);
    RE = 1'b1; RADDR = 10'd9;
    tick();
    RE = 1'b0; RST = 1'b1;
    tick();
    RST = 1'b0;
    checks += 6;
    if (RD_VALID !== 1'b0) begin failures++; $display("FAIL rst_rd_valid got=%b exp=0", RD_VALID); end
    if (RD !== '0)         begin failures++; $display("FAIL rst_rd got=%h exp=0", RD); end
    if (R_AVAIL !== 1'b0)  begin failures++; $display("FAIL rst_r_avail got=%b exp=0", R_AVAIL); end
    if (W_AVAIL !== 1'b1)  begin failures++; $display("FAIL rst_w_avail got=%b exp=1", W_AVAIL); end
    if (W_BANK !== '0)     begin failures++; $display("FAIL rst_w_bank got=%0d exp=0", W_BANK); end
    if (R_BANK !== '0)     begin failures++; $display("FAIL rst_r_bank got=%0d exp=0", R_BANK); end
    tick();
    checks++;
    if (RD_VALID !== 1'b0) begin failures++; $display("FAIL rst_late_valid got=%b exp=0", RD_VALID); end
  endtask

  task automatic test_random();
    int nerr = 0;
    for (int b = 0; b < NB; b++) begin
      for (int a = 0; a < PW; a++) write_word(a, DW'($urandom), 4'hF);
      commit(PW);
    end
    repeat (NB) release_bank();
    for (int c = 0; c < 3000; c++) begin
      WE        = ($urandom_range(0, 9) < 6);
      WADDR     = AW'($urandom_range(0, PW + 3));
      WD        = DW'($urandom);
      WBE       = 4'($urandom);
      W_COMMIT  = ($urandom_range(0, 19) == 0);
      W_LEN     = LW'($urandom_range(0, PW + 80));
      RE        = ($urandom_range(0, 9) < 6);
      RADDR     = AW'($urandom_range(0, PW + 2));
      R_RELEASE = ($urandom_range(0, 17) == 0);
      tick();
      checks += 6;
      if (RD_VALID !== e_rv) begin failures++; nerr++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, RD_VALID, e_rv); end
      if (RD !== e_rd) begin failures++; nerr++; $display("FAIL rnd_rd c=%0d got=%h exp=%h", c, RD, e_rd); end
      if (W_AVAIL !== (m_cnt < NB)) begin failures++; nerr++; $display("FAIL rnd_w_avail c=%0d got=%b exp=%b", c, W_AVAIL, (m_cnt < NB)); end
      if (R_AVAIL !== (m_cnt > 0)) begin failures++; nerr++; $display("FAIL rnd_r_avail c=%0d got=%b exp=%b", c, R_AVAIL, (m_cnt > 0)); end
      if (W_BANK !== BW'(m_wp)) begin failures++; nerr++; $display("FAIL rnd_w_bank c=%0d got=%0d exp=%0d", c, W_BANK, m_wp); end
      if (R_BANK !== BW'(m_rp)) begin failures++; nerr++; $display("FAIL rnd_r_bank c=%0d got=%0d exp=%0d", c, R_BANK, m_rp); end
      if (m_cnt > 0) begin
        checks++;
        if (R_LEN !== LW'(m_len[m_rp])) begin
          failures++; nerr++; $display("FAIL rnd_r_len c=%0d got=%0d exp=%0d", c, R_LEN, m_len[m_rp]);
        end
      end
      if (nerr > 20) break;
    end
    set_idle();
  endtask

  initial begin
    RST = 1'b1;
    set_idle();
    test_reset();
    test_fill_drain();
    test_byte_enable();
    test_ping_pong();
    test_commit_release();
    test_oob_empty();
    test_rst_inflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
